// File: rtl/dr_pkg.sv
// Shared types and helpers for the dual-rail sink: FSM states, FIFO count width, per-bit rail decode.
package dr_pkg;

   typedef enum logic [0:0] {WAIT_DATA, WAIT_NULL} dr_sink_state_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic bit_valid(input logic t, input logic f);
      return t ^ f;
   endfunction

   function automatic logic bit_null(input logic t, input logic f);
      return ~t & ~f;
   endfunction

   function automatic logic bit_illegal(input logic t, input logic f);
      return t & f;
   endfunction

endpackage

// File: rtl/dr_sink_fifo.sv
// Small synchronous FIFO; push lands next edge, head is 0 while empty.
// Push while full is accepted only when a pop happens on the same edge.
module dr_sink_fifo
   import dr_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic          ck,
   input  logic          reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_push_dat,
   input  logic          i_pop,
   output logic          o_full,
   output logic          o_empty,
   output logic [W-1:0]  o_head,
   output logic [CW-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge ck) begin
      if (w_push) r_mem[r_wp] <= i_push_dat;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head  = o_empty ? '0 : r_mem[r_rp];
   assign o_count = r_cnt;

endmodule

// File: rtl/dr_sink.sv
// Dual-rail four-phase RZ receiver: completion -> FIFO push + d_ack one edge later; full FIFO withholds d_ack.
// Optional sticky illegal-code flag err under DR_SINK_ILLEGAL_CHECK_EN.
module dr_sink
   import dr_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         ck,
   input  logic         reset,
   input  logic [W-1:0] d_t,
   input  logic [W-1:0] d_f,
   output logic         d_ack,
   output logic [W-1:0] q_data,
   output logic         q_valid,
   input  logic         q_ready
`ifdef DR_SINK_ILLEGAL_CHECK_EN
   ,
   output logic         err
`endif
);

   localparam int CW = cnt_width(DEPTH);

   dr_sink_state_e r_state;
   dr_sink_state_e w_state_nxt;
   logic           r_ack;
   logic           w_ack_nxt;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic           w_complete;
   logic           w_spacer;
   logic [W-1:0]   w_valid;
   logic [W-1:0]   w_null;
   logic [CW-1:0]  w_count;

   always_comb begin
      w_valid = '0;
      w_null  = '0;
      for (int i = 0; i < W; i++) begin
         w_valid[i] = bit_valid(d_t[i], d_f[i]);
         w_null[i]  = bit_null(d_t[i], d_f[i]);
      end
   end

   // An illegal bit is neither valid nor null, so it stalls both states on its own.
   assign w_complete = &w_valid;
   assign w_spacer   = &w_null;
   assign q_valid    = ~w_empty;
   assign w_pop      = q_valid & q_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = r_ack;
      w_push      = 1'b0;
      case (r_state)
         WAIT_DATA: begin
            if (w_complete && (!w_full || w_pop)) begin
               w_push      = 1'b1;
               w_ack_nxt   = 1'b1;
               w_state_nxt = WAIT_NULL;
            end
         end
         WAIT_NULL: begin
            if (w_spacer) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = WAIT_DATA;
            end
         end
         default: begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = WAIT_DATA;
         end
      endcase
   end

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_state <= WAIT_DATA;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
      end
   end

   assign d_ack = r_ack;

   dr_sink_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .ck         (ck),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (d_t),
      .i_pop      (w_pop),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_head     (q_data),
      .o_count    (w_count)
   );

   a_count_bound: assert property (@(posedge ck) disable iff (!reset) w_count <= CW'(DEPTH));

`ifdef DR_SINK_ILLEGAL_CHECK_EN
   logic [W-1:0] w_illegal;
   logic         r_err;

   always_comb begin
      w_illegal = '0;
      for (int i = 0; i < W; i++) w_illegal[i] = bit_illegal(d_t[i], d_f[i]);
   end

   always_ff @(posedge ck or negedge reset) begin
      if (!reset)          r_err <= 1'b0;
      else if (|w_illegal) r_err <= 1'b1;
   end

   assign err = r_err;
`endif

endmodule

// File: doc/dr_sink.md
Name: dr_sink

Overview:
- Receiving end of a dual-rail four-phase return-to-zero channel, as produced by the team's drwire register and tie cells.
- Observes a W-bit dual-rail word and detects completion (every bit valid) and spacer (every bit null).
- Captures completed words into a small synchronous FIFO and drives the channel acknowledge.
- Presents the words on a single-rail valid/ready port for clocked consumers, such as test harnesses and sync-domain logic.

Parameters:
- W, 8, data width in bits (dual-rail pairs).
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- ck  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- d_t  input  W  true rails of the incoming dual-rail word.
- d_f  input  W  false rails of the incoming dual-rail word.
- d_ack  output  1  channel acknowledge; 1 means data accepted and holding, 0 means ready for data.
- q_data  output  W  single-rail head-of-FIFO word.
- q_valid  output  1  FIFO non-empty.
- q_ready  input  1  consumer accepts q_data when q_valid and q_ready are both high at a ck edge.
- err  output  1  sticky illegal-code flag; present only with the optional feature.

Behaviour:
- Inputs are driven by ck-gated latches in the same clock domain, so no synchronisers are used.
- Per-bit decode: valid = t XOR f; null = NOT t AND NOT f; illegal = t AND f.
- complete = all W bits valid; spacer = all W bits null.
- Asynchronous reset (reset=0):
  - d_ack=0, q_valid=0, q_data=0, FIFO empty, state WAIT_DATA, err=0.
  - Reset asserted mid-handshake aborts the word and drops d_ack immediately.
  - After release, the block waits in WAIT_DATA; a word still present on the bus is taken as new data.
- State WAIT_DATA:
  - Rising edge with complete=1 and (FIFO not full, or a pop occurs the same edge): push word (the d_t vector), set d_ack=1, go to WAIT_NULL.
  - Partial word (neither complete nor spacer): hold, no push.
  - complete=1 with FIFO full and no pop: hold and do not acknowledge (backpressure onto the channel).
- State WAIT_NULL:
  - d_ack stays 1 until an edge samples spacer=1.
  - Then d_ack=0 and the state returns to WAIT_DATA.
  - Partial nulls: hold.
- Latency: complete sampled at edge N gives d_ack=1 and q_valid=1 after edge N, with the word visible at q_data if the FIFO was empty. d_ack and q_data are registered outputs.
- Each word is pushed exactly once per four-phase cycle. Re-push is impossible until a spacer has been observed.
- FIFO:
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - Pop occurs when q_valid and q_ready are both high at an edge.
  - Simultaneous push and pop when full: both happen and count is unchanged.
  - Simultaneous push and pop when empty: the pushed word appears next cycle and no pop occurs.
  - q_data equals the head entry, or 0 when empty.
- Throughput: at most one word every 2 ck cycles (data edge plus spacer edge).

Optional Feature:
- Macro DR_SINK_ILLEGAL_CHECK_EN.
- Defined:
  - err is set on any edge where any bit has t=f=1.
  - err is sticky until reset.
  - A word containing an illegal bit is never pushed; the FSM holds in its current state.
- Undefined:
  - err port absent.
  - illegal bits are treated as not valid and not null; the FSM simply waits.

Decomposition:
- Package dr_pkg holds:
  - typedef enum dr_sink_state_e {WAIT_DATA, WAIT_NULL};
  - localparam function for the count width.
  - per-bit decode helper functions for valid, null and illegal.
- One sub-module, dr_sink_fifo: parameterised W/DEPTH synchronous FIFO with push, pop, full, empty, head and count, and asynchronous active-low reset.
- FSM, completion detection and error logic stay in dr_sink.

Test Plan:
- Basic handshake:
  - Stimulus: reset release; drive d_t=8'hA5, d_f=8'h5A.
  - Response: d_ack=1 and q_valid=1 with q_data=8'hA5 one edge later.
  - Then drive spacer: d_ack=0 after the next edge.
  - Pop with q_ready=1: q_valid=0.
- Partial word:
  - Stimulus: drive t/f on bits 0-6 only for 5 cycles.
  - Response: d_ack stays 0 and no push.
  - Then complete bit 7: d_ack=1 on the following edge.
- Backpressure:
  - Stimulus: q_ready=0; send 3 words (DEPTH=2).
  - Response: the third word is held complete with d_ack=0.
  - Then assert q_ready=1 for one cycle: pop and push occur together; d_ack=1; FIFO count remains 2.
- Order and wrap:
  - Stimulus: send words 0x00..0x09 with q_ready toggling each cycle.
  - Response: q_data sequence is exactly 0x00..0x09 with no duplicates across pointer wrap.
- Reset mid-handshake:
  - Stimulus: in WAIT_NULL with d_ack=1, pulse reset low asynchronously between edges.
  - Response: d_ack=0 and q_valid=0 immediately.
  - With the word still present after release: recaptured and d_ack=1 on the first edge.
- Illegal code (DR_SINK_ILLEGAL_CHECK_EN):
  - Stimulus: drive bit 3 with t=f=1 and the other bits valid.
  - Response: err=1 after the edge, no push, d_ack=0.
  - err stays 1 through subsequent legal traffic until reset.
